tone_divider_bank: RTL and testbench
====================================

TONE_DIVIDER_BANK -- requirements
Module: tone_divider_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 32: width of the divide value and of each counter.
REQ-003 The block SHALL have parameter CH_W, default $clog2(NUM_CH) with a minimum of 1: width of the channel select.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port wr_en, input, 1 bit: a one-cycle strobe that writes wr_div to channel wr_ch.
REQ-007 The block SHALL have port wr_ch, input, CH_W bits: the target channel of a write.
REQ-008 The block SHALL have port wr_div, input, CNT_W bits: the new divide value.
REQ-009 The block SHALL have port ch_en, input, NUM_CH bits: per-channel run enable.
REQ-010 The block SHALL have port clk_out, output, NUM_CH bits: per-channel square wave.
REQ-011 The block SHALL have port tick, output, NUM_CH bits: per-channel one-cycle pulse on each clk_out edge.
REQ-012 The block SHALL have port pend, output, NUM_CH bits: per-channel flag meaning a written value is waiting to be applied.

Function
REQ-013 Each channel SHALL hold a shadow divide register, an active divide register, a CNT_W-bit counter and an output toggle.
REQ-014 An enabled channel SHALL increment its counter each cycle while counter < active, and at counter >= active SHALL clear the counter, invert clk_out, pulse tick and copy shadow into active.
REQ-015 The half-period SHALL be active+1 cycles; active=0 SHALL toggle clk_out every cycle; active=2^CNT_W-1 SHALL NOT overflow the counter.
REQ-016 A write SHALL load shadow and set pend on the next edge; pend SHALL clear on the boundary that copies shadow into active.
REQ-017 A write landing in the same cycle as a boundary SHALL leave the boundary using the old shadow, so the new value stays pending until the following boundary.
REQ-018 A write with wr_ch >= NUM_CH SHALL be ignored.
REQ-019 A disabled channel SHALL hold counter=0, clk_out=0 and tick=0; a write to it SHALL load shadow and active together, with pend staying 0.
REQ-020 A 0->1 transition on ch_en SHALL start the channel with counter=0 and clk_out=0; the first toggle SHALL occur active+1 cycles after the cycle in which ch_en is first sampled high.
REQ-021 A 1->0 transition on ch_en mid-period SHALL force clk_out=0 and counter=0 on the next edge, with no tick.
REQ-022 tick and clk_out SHALL be registered with zero added latency relative to the counter boundary: tick is high exactly in the cycle after the edge in which clk_out changed.
REQ-023 Channels SHALL be fully independent; simultaneous boundaries on several channels SHALL all be honoured in the same cycle.

Reset
REQ-024 On rst=1 at a clk edge, every counter, clk_out, tick and pend SHALL become 0, and every shadow and active register SHALL become 0.
REQ-025 rst SHALL take priority over wr_en and ch_en in the same cycle; a write coincident with reset SHALL be lost.
REQ-026 Reset asserted mid-period SHALL abort the period with no tick.

Structure
REQ-027 Package tone_pkg SHALL hold the NUM_CH and CNT_W defaults and a divide-value typedef of width CNT_W.
REQ-028 Sub-module tone_divider_channel SHALL implement one channel (shadow, active, counter, toggle, pend) and SHALL be instantiated NUM_CH times by generate; the top SHALL only decode writes.

Verification
REQ-029 Reset, then write ch0 div=3 with ch_en[0] held 0, then enable -> clk_out[0] toggles every 4 cycles (period 8), one tick per toggle, pend[0] stays 0.
REQ-030 Ch0 running at div=3, write div=1 mid-period -> pend[0]=1 until the current half-period completes at 4 cycles, then half-periods of 2 cycles and pend[0]=0.
REQ-031 Write timed to coincide with a boundary on a running channel -> the next half-period still uses the old value, and the new value applies one boundary later.
REQ-032 div=0 on ch1 and div=5 on ch2, both enabled -> ch1 toggles every cycle with tick held high continuously, ch2 has period 12, and neither channel perturbs the other.
REQ-033 Write with wr_ch=NUM_CH, and separately wr_en coincident with rst -> no register changes, all outputs 0 after the reset.
REQ-034 Drop ch_en mid-period, then reassert it after 3 cycles -> clk_out=0 the next cycle with no tick, and on restart the first toggle comes after a full active+1 cycles.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants and types for the tone divider bank.
// Defaults here size the bank when the parent sets no parameters.
package tone_pkg;

  localparam int TONE_NUM_CH = 4;
  localparam int TONE_CNT_W  = 32;

  typedef logic [TONE_CNT_W-1:0] div_t;

  // Channel-select width: clog2 of the channel count, never below 1.
  function automatic int tone_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tone_divider_channel.sv
// One divider channel: shadow/active divide, counter and output toggle.
// A half-period lasts active+1 cycles; shadow is applied on each boundary.
module tone_divider_channel
  import tone_pkg::*;
#(
  parameter int CNT_W = TONE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] cnt;
  logic             hit;

  // Boundary: counter has reached the active divide value.
  assign hit = (cnt >= active);

  // Divide registers: writes land in shadow; boundaries promote shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
      pend   <= 1'b0;
    end else if (!en) begin
      if (wr) begin
        shadow <= wr_div;
        active <= wr_div;
        pend   <= 1'b0;
      end
    end else begin
      if (hit) begin
        active <= shadow;
        pend   <= 1'b0;
      end
      if (wr) begin
        shadow <= wr_div;
        pend   <= 1'b1;
      end
    end
  end

  // Counter and toggle; a disabled channel idles low at count zero.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (hit) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
      tick    <= 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/tone_divider_bank.sv
// Bank of independent tone dividers sharing one write port.
// The top only decodes the write strobe onto the addressed channel.
module tone_divider_bank
  import tone_pkg::*;
#(
  parameter int NUM_CH = TONE_NUM_CH,
  parameter int CNT_W  = TONE_CNT_W,
  parameter int CH_W   = tone_ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  logic [NUM_CH-1:0] ch_wr;

  // Out-of-range selects match no channel and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_wr[i] = wr_en && (wr_ch == CH_W'(i));

    tone_divider_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[i]),
      .wr      (ch_wr[i]),
      .wr_div  (wr_div),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_tone_divider_bank.sv
// Self-checking bench for tone_divider_bank.
// Behavioural per-channel model plus directed literal expectations.
module tb_tone_divider_bank;
  localparam int N  = 3;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [CW-1:0] wr_ch;
  logic [W-1:0]  wr_div;
  logic [N-1:0]  ch_en;
  logic [N-1:0]  clk_out;
  logic [N-1:0]  tick;
  logic [N-1:0]  pend;

  int errors = 0;
  int checks = 0;

  int m_sh[N];
  int m_ac[N];
  int m_el[N];
  bit m_out[N];
  bit m_tk[N];
  bit m_pd[N];

  tone_divider_bank #(
    .NUM_CH (N),
    .CNT_W  (W),
    .CH_W   (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .ch_en   (ch_en),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: a half-period is active+1 cycles of elapsed time.
  task automatic model_step();
    bit wr;
    for (int c = 0; c < N; c++) begin
      wr = wr_en && (int'(wr_ch) == c);
      if (rst) begin
        m_sh[c] = 0; m_ac[c] = 0; m_el[c] = 0;
        m_out[c] = 0; m_tk[c] = 0; m_pd[c] = 0;
      end else if (!ch_en[c]) begin
        m_out[c] = 0; m_tk[c] = 0; m_el[c] = 0;
        if (wr) begin
          m_sh[c] = int'(wr_div);
          m_ac[c] = int'(wr_div);
          m_pd[c] = 0;
        end
      end else begin
        if (m_el[c] == m_ac[c]) begin
          m_out[c] = !m_out[c];
          m_tk[c] = 1;
          m_el[c] = 0;
          m_ac[c] = m_sh[c];
          m_pd[c] = 0;
        end else begin
          m_el[c]++;
          m_tk[c] = 0;
        end
        if (wr) begin
          m_sh[c] = int'(wr_div);
          m_pd[c] = 1;
        end
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] eo, et, ep;
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < N; c++) begin
      eo[c] = m_out[c];
      et[c] = m_tk[c];
      ep[c] = m_pd[c];
    end
    chk("model clk_out", 32'(clk_out), 32'(eo));
    chk("model tick", 32'(tick), 32'(et));
    chk("model pend", 32'(pend), 32'(ep));
  endtask

  task automatic cyc(input bit r, input bit we, input int ch,
                     input int dv, input logic [N-1:0] en);
    rst    = r;
    wr_en  = we;
    wr_ch  = ch[CW-1:0];
    wr_div = dv[W-1:0];
    ch_en  = en;
    step();
  endtask

  task automatic run(input int n, input logic [N-1:0] en);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, en);
  endtask

  bit seq_o[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  bit seq_t[8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    logic [N-1:0] en;
    rst = 1; wr_en = 0; wr_ch = 0; wr_div = 0; ch_en = 0;
    cyc(1, 0, 0, 0, 3'b000);
    cyc(1, 0, 0, 0, 3'b000);
    chk("reset clk_out", 32'(clk_out), 0);
    chk("reset tick", 32'(tick), 0);
    chk("reset pend", 32'(pend), 0);

    // div=3 written while disabled, then enabled: half-period 4.
    cyc(0, 1, 0, 3, 3'b000);
    chk("dis write pend", 32'(pend[0]), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 3'b001);
      chk("div3 clk_out", 32'(clk_out[0]), 32'(seq_o[i]));
      chk("div3 tick", 32'(tick[0]), 32'(seq_t[i]));
      chk("div3 pend", 32'(pend[0]), 0);
    end

    // Mid-period write of div=1 waits for the current boundary.
    run(1, 3'b001);
    cyc(0, 1, 0, 1, 3'b001);
    run(1, 3'b001);
    chk("mid wr pend", 32'(pend[0]), 1);
    chk("mid wr out", 32'(clk_out[0]), 0);
    run(1, 3'b001);
    chk("apply out", 32'(clk_out[0]), 1);
    chk("apply pend", 32'(pend[0]), 0);
    run(1, 3'b001);
    chk("div1 hold", 32'(clk_out[0]), 1);
    run(1, 3'b001);
    chk("div1 toggle", 32'(clk_out[0]), 0);

    // Write on a boundary cycle: old value used once more.
    run(1, 3'b001);
    cyc(0, 1, 0, 2, 3'b001);
    chk("bnd wr out", 32'(clk_out[0]), 1);
    chk("bnd wr pend", 32'(pend[0]), 1);
    run(2, 3'b001);
    chk("bnd old out", 32'(clk_out[0]), 0);
    chk("bnd old pend", 32'(pend[0]), 0);
    run(2, 3'b001);
    chk("bnd new hold", 32'(clk_out[0]), 0);
    run(1, 3'b001);
    chk("bnd new out", 32'(clk_out[0]), 1);

    // Drop enable mid-period, then restart after 3 cycles.
    run(1, 3'b001);
    cyc(0, 0, 0, 0, 3'b000);
    chk("drop out", 32'(clk_out[0]), 0);
    chk("drop tick", 32'(tick[0]), 0);
    run(3, 3'b000);
    run(2, 3'b001);
    chk("restart hold", 32'(clk_out[0]), 0);
    run(1, 3'b001);
    chk("restart out", 32'(clk_out[0]), 1);

    // ch1 div=0 and ch2 div=5 side by side.
    cyc(1, 0, 0, 0, 3'b000);
    cyc(0, 1, 1, 0, 3'b000);
    cyc(0, 1, 2, 5, 3'b000);
    for (int i = 1; i <= 24; i++) begin
      cyc(0, 0, 0, 0, 3'b110);
      chk("ch1 tick", 32'(tick[1]), 1);
      chk("ch1 out", 32'(clk_out[1]), 32'(i % 2));
      chk("ch2 out", 32'(clk_out[2]), 32'((i / 6) % 2));
    end

    // Out-of-range channel and write coincident with reset.
    cyc(1, 0, 0, 0, 3'b000);
    cyc(0, 1, 3, 7, 3'b000);
    cyc(1, 1, 0, 9, 3'b000);
    chk("rstwr out", 32'(clk_out), 0);
    chk("rstwr pend", 32'(pend), 0);
    cyc(0, 0, 0, 0, 3'b111);
    chk("rstwr div0", 32'(clk_out), 32'(3'b111));

    // Largest divide value: half-period 2^W cycles.
    cyc(1, 0, 0, 0, 3'b000);
    cyc(0, 1, 0, 255, 3'b000);
    run(255, 3'b001);
    chk("max hold", 32'(clk_out[0]), 0);
    run(1, 3'b001);
    chk("max out", 32'(clk_out[0]), 1);
    chk("max tick", 32'(tick[0]), 1);

    // Randomized traffic against the model.
    en = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 39) == 0) en[c] = !en[c];
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                      : int'($urandom_range(0, 6)),
          en);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
